// File: rtl/lpc_sink_ram_ctrl.sv
// lpc_sink_ram_ctrl
// Write-side sequencer for the LPC sink RAM. Accepts an Avalon-ST sample
// stream and writes it into one port of the dual-port RAM as a ping-pong
// frame buffer: two banks of 2^(ADDR_W-1) words each. Each completed frame
// is reported to the host, which reads it through the other RAM port and
// acknowledges it. When both banks are full the source is back-pressured
// and a sticky overflow flag records the stall; no samples are dropped.
//
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   enable                 capture enable (resumes mid-frame when re-raised)
//   snk_data/valid/ready   Avalon-ST sink for samples
//   ram_address/chipselect/write/writedata/byteenable
//                          Avalon-MM master towards the RAM write port;
//                          address is {bank, idx}
//   frame_ready            at least one full bank awaits acknowledge
//   frame_bank             oldest full bank (valid while frame_ready)
//   frame_ack              one-cycle pulse freeing frame_bank
//   overflow, overflow_clr sticky stall flag and its clear
//   frame_count            completed frames, wraps at 16 bits
module lpc_sink_ram_ctrl #(
  parameter int ADDR_W    = 13,
  parameter int DATA_W    = 16,
  parameter int FRAME_LEN = 160
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic [DATA_W-1:0]   snk_data,
  input  logic                snk_valid,
  output logic                snk_ready,
  output logic [ADDR_W-1:0]   ram_address,
  output logic                ram_chipselect,
  output logic                ram_write,
  output logic [DATA_W-1:0]   ram_writedata,
  output logic [DATA_W/8-1:0] ram_byteenable,
  output logic                frame_ready,
  output logic                frame_bank,
  input  logic                frame_ack,
  output logic                overflow,
  input  logic                overflow_clr,
  output logic [15:0]         frame_count
);

  localparam int IDX_W = ADDR_W - 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FILL      = 2'd1,
    WAIT_FREE = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [1:0]         full, full_nxt;
  logic               wr_bank, wr_bank_nxt;
  logic               rd_bank;
  logic [IDX_W-1:0]   idx;
  logic               accept;
  logic               last_beat;
  logic               ack_eff;

  logic               wr_p1;
  logic [ADDR_W-1:0]  addr_p1;
  logic [DATA_W-1:0]  data_p1;

  assign snk_ready = (state == FILL);
  assign accept    = snk_valid & snk_ready;
  assign last_beat = accept && (idx == LAST_IDX);
  // An ack with nothing pending is ignored.
  assign ack_eff   = frame_ack & (|full);

  // Bank occupancy after this edge. The acked bank is always the older one,
  // so it can never be the bank being completed in the same cycle.
  always_comb begin
    full_nxt = full;
    if (ack_eff)   full_nxt[rd_bank] = 1'b0;
    if (last_beat) full_nxt[wr_bank] = 1'b1;
  end

  assign wr_bank_nxt = last_beat ? ~wr_bank : wr_bank;

  // Whenever capture is enabled the FSM is in FILL exactly when the bank it
  // will write next is free after this edge; using the post-ack occupancy
  // lets a coincident ack skip the WAIT_FREE cycle.
  always_comb begin
    state_nxt = state;
    if (!enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE, FILL, WAIT_FREE:
          state_nxt = full_nxt[wr_bank_nxt] ? WAIT_FREE : FILL;
        default:
          state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      full        <= 2'b00;
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b0;
      idx         <= '0;
      frame_count <= 16'd0;
      overflow    <= 1'b0;
    end else begin
      state   <= state_nxt;
      full    <= full_nxt;
      wr_bank <= wr_bank_nxt;
      if (ack_eff) rd_bank <= ~rd_bank;
      if (accept) idx <= last_beat ? '0 : idx + 1'b1;
      if (last_beat) frame_count <= frame_count + 16'd1;
      // Set has priority over a simultaneous clear.
      if (state == WAIT_FREE && snk_valid) overflow <= 1'b1;
      else if (overflow_clr)               overflow <= 1'b0;
    end
  end

  // Stage p1: registered RAM write, one cycle after the accepted beat.
  // Address and data hold their last values between writes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_p1   <= 1'b0;
      addr_p1 <= '0;
      data_p1 <= '0;
    end else begin
      wr_p1 <= accept;
      if (accept) begin
        addr_p1 <= {wr_bank, idx};
        data_p1 <= snk_data;
      end
    end
  end

  assign ram_chipselect = wr_p1;
  assign ram_write      = wr_p1;
  assign ram_address    = addr_p1;
  assign ram_writedata  = data_p1;
  assign ram_byteenable = '1;

  assign frame_ready = |full;
  assign frame_bank  = rd_bank;

endmodule

// File: tb/tb_lpc_sink_ram_ctrl.sv
// Self-checking bench for lpc_sink_ram_ctrl. A stimulus thread drives
// directed scenarios and a randomized phase; a monitor thread keeps a
// frame-level reference model (beat counter, queue of pending frames) and a
// scoreboard queue of expected RAM writes, and compares every DUT output
// each cycle.
module tb_lpc_sink_ram_ctrl;

  localparam int ADDR_W     = 13;
  localparam int DATA_W     = 16;
  localparam int FRAME_LEN  = 160;
  localparam int BANK_WORDS = 1 << (ADDR_W - 1);

  logic                clk = 1'b0;
  logic                reset_n;
  logic                enable;
  logic [DATA_W-1:0]   snk_data;
  logic                snk_valid;
  logic                snk_ready;
  logic [ADDR_W-1:0]   ram_address;
  logic                ram_chipselect;
  logic                ram_write;
  logic [DATA_W-1:0]   ram_writedata;
  logic [DATA_W/8-1:0] ram_byteenable;
  logic                frame_ready;
  logic                frame_bank;
  logic                frame_ack;
  logic                overflow;
  logic                overflow_clr;
  logic [15:0]         frame_count;

  always #5 clk = ~clk;

  lpc_sink_ram_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .snk_data(snk_data), .snk_valid(snk_valid), .snk_ready(snk_ready),
    .ram_address(ram_address), .ram_chipselect(ram_chipselect),
    .ram_write(ram_write), .ram_writedata(ram_writedata),
    .ram_byteenable(ram_byteenable),
    .frame_ready(frame_ready), .frame_bank(frame_bank), .frame_ack(frame_ack),
    .overflow(overflow), .overflow_clr(overflow_clr), .frame_count(frame_count)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } wr_t;

  wr_t wq[$];           // expected RAM writes
  bit  pend[$];         // full banks, oldest first
  int  m_idx, m_cnt;
  bit  m_wb, m_ovf, m_wait, m_rdy;
  logic [ADDR_W-1:0] last_a;
  logic [DATA_W-1:0] last_d;

  // values sampled just before each rising edge
  logic s_rst, s_en, s_val, s_rdy, s_ack, s_clr, s_acc;
  logic [DATA_W-1:0] s_dat;

  function automatic bit in_pend(input bit b);
    foreach (pend[i]) if (pend[i] == b) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    wq.delete(); pend.delete();
    m_idx = 0; m_cnt = 0; m_wb = 0; m_ovf = 0; m_wait = 0; m_rdy = 0;
    last_a = '0; last_d = '0;
  endtask

  task automatic model_step();
    wr_t e;
    bit ack_ok;
    ack_ok = s_ack && (pend.size() != 0);
    if (m_wait && s_val) m_ovf = 1'b1;
    else if (s_clr)      m_ovf = 1'b0;
    if (ack_ok) void'(pend.pop_front());
    if (s_acc) begin
      e.a = ADDR_W'(int'(m_wb) * BANK_WORDS + m_idx);
      e.d = s_dat;
      wq.push_back(e);
      m_idx++;
      if (m_idx == FRAME_LEN) begin
        m_idx = 0;
        pend.push_back(m_wb);
        m_wb = !m_wb;
        m_cnt++;
      end
    end
    // Enabled capture stalls exactly when the bank to be written is occupied.
    m_wait = s_en && in_pend(m_wb);
    m_rdy  = s_en && !in_pend(m_wb);
  endtask

  initial begin
    model_reset();
    forever begin
      @(negedge clk); #4;
      s_rst = reset_n; s_en = enable; s_val = snk_valid; s_rdy = snk_ready;
      s_dat = snk_data; s_ack = frame_ack; s_clr = overflow_clr;
      s_acc = s_val & s_rdy;
      @(posedge clk); #1;
      if (s_rst !== 1'b1) model_reset();
      else                model_step();

      chk("ram_write", ram_write, wq.size() != 0);
      chk("ram_chipselect", ram_chipselect, wq.size() != 0);
      if (wq.size() != 0) begin
        wr_t e;
        e = wq.pop_front();
        chk("ram_address", ram_address, e.a);
        chk("ram_writedata", ram_writedata, e.d);
        last_a = e.a; last_d = e.d;
      end else begin
        chk("addr_hold", ram_address, last_a);
        chk("data_hold", ram_writedata, last_d);
      end
      chk("snk_ready", snk_ready, m_rdy);
      chk("frame_ready", frame_ready, pend.size() != 0);
      if (pend.size() != 0) chk("frame_bank", frame_bank, pend[0]);
      chk("overflow", overflow, m_ovf);
      chk("frame_count", frame_count, 16'(m_cnt));
      chk("byteenable", ram_byteenable, {(DATA_W/8){1'b1}});
    end
  end

  // ---------------- stimulus ----------------
  // All tasks start and end at a falling edge.
  task automatic send(input logic [DATA_W-1:0] d, input bit ack);
    int n;
    snk_valid = 1'b1; snk_data = d; frame_ack = ack;
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (!s_acc && n < 5000);
    @(negedge clk);
    snk_valid = 1'b0; frame_ack = 1'b0;
    n_checks++;
    if (!s_acc) begin
      n_fail++;
      $display("FAIL send_timeout: beat %0h not accepted after %0d cycles", d, n);
    end
  endtask

  task automatic send_n(input int n, input int base, input int max_gap);
    for (int i = 0; i < n; i++) begin
      if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(negedge clk);
      send(DATA_W'(base + i), 1'b0);
    end
  endtask

  task automatic ack_pulse();
    frame_ack = 1'b1;
    @(negedge clk);
    frame_ack = 1'b0;
  endtask

  initial begin
    int t0;
    reset_n = 1'b0; enable = 1'b0; snk_data = '0; snk_valid = 1'b0;
    frame_ack = 1'b0; overflow_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_address", ram_address, 0);
    chk("rst_frame_ready", frame_ready, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Fill one frame back-to-back
    enable = 1'b1;
    @(negedge clk);
    t0 = cyc;
    send_n(FRAME_LEN, 0, 0);
    chk("frame1_throughput", cyc - t0, FRAME_LEN);
    @(negedge clk);
    chk("frame1_ready", frame_ready, 1);
    chk("frame1_bank", frame_bank, 0);
    chk("frame1_count", frame_count, 1);

    // Second frame without ack: both banks full
    send_n(FRAME_LEN, 1000, 0);
    @(negedge clk);
    chk("both_full_ready", snk_ready, 0);

    // Held valid while stalled sets overflow, no writes
    snk_valid = 1'b1; snk_data = 16'h0007;
    repeat (4) @(negedge clk);
    chk("ovf_set", overflow, 1);
    ack_pulse();
    chk("ack_frees_ready", snk_ready, 1);
    chk("ack_bank", frame_bank, 1);
    send(16'h0007, 1'b0);
    overflow_clr = 1'b1;
    @(negedge clk);
    overflow_clr = 1'b0;
    chk("ovf_clr", overflow, 0);
    ack_pulse();
    chk("all_acked", frame_ready, 0);

    // Completion coinciding with ack of the other bank
    send_n(FRAME_LEN - 1, 200, 0);
    ack_pulse();
    send_n(FRAME_LEN, 400, 0);
    send_n(FRAME_LEN - 1, 600, 0);
    send(16'h0ABC, 1'b1);
    chk("simul_ready", snk_ready, 1);
    chk("simul_bank", frame_bank, 0);
    send_n(3, 900, 0);
    ack_pulse();

    // Mid-frame reset
    send_n(50, 2000, 0);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("mrst_address", ram_address, 0);
    chk("mrst_data", ram_writedata, 0);
    chk("mrst_count", frame_count, 0);
    chk("mrst_ready", snk_ready, 0);
    reset_n = 1'b1;
    send_n(FRAME_LEN, 3000, 0);
    chk("post_rst_count", frame_count, 1);
    ack_pulse();

    // Gaps and an enable drop mid-frame
    send_n(80, 4000, 3);
    enable = 1'b0;
    snk_valid = 1'b1;
    repeat (10) @(negedge clk);
    snk_valid = 1'b0;
    enable = 1'b1;
    send_n(FRAME_LEN - 80, 4080, 3);
    @(negedge clk);
    chk("gap_count", frame_count, 2);
    ack_pulse();

    // Randomized mix of traffic, acks, clears and enable drops
    for (int i = 0; i < 4000; i++) begin
      snk_valid    = ($urandom_range(0, 99) < 70);
      snk_data     = DATA_W'($urandom);
      frame_ack    = ($urandom_range(0, 99) < 3);
      overflow_clr = ($urandom_range(0, 99) < 2);
      enable       = ($urandom_range(0, 99) < 97);
      @(negedge clk);
    end
    snk_valid = 1'b0; frame_ack = 1'b0; overflow_clr = 1'b0;
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lpc_sink_ram_ctrl.md
# lpc_sink_ram_ctrl

Write-side sequencer for the LPC sink RAM: 8192 × 16 true dual-port, Avalon-MM slave on each port. It takes a 16-bit Avalon-ST sample stream from the LPC datapath and writes it into one RAM port as a ping-pong frame buffer, using two banks of `2^(ADDR_W-1)` words. It signals each completed frame to the host/Nios side, which reads the frame through the other RAM port and acknowledges it. It also flags overflow when the source stalls because both banks are full.

## Interface
- `ADDR_W`, 13: RAM word-address width. Bank size is `BANK_WORDS = 2^(ADDR_W-1)`.
- `DATA_W`, 16: sample and RAM data width.
- `FRAME_LEN`, 160: samples per frame. Legal range 1..BANK_WORDS.

- `clk`  in  1: single clock for all logic.
- `reset_n`  in  1: asynchronous, active-low reset.
- `enable`  in  1: capture enable.
- `snk_data`  in  DATA_W: sample.
- `snk_valid`  in  1: sample valid.
- `snk_ready`  out  1: sample accepted when `snk_valid & snk_ready`.
- `ram_address`  out  ADDR_W: word address, `{bank, idx}`.
- `ram_chipselect`  out  1: RAM select.
- `ram_write`  out  1: RAM write strobe.
- `ram_writedata`  out  DATA_W: RAM write data.
- `ram_byteenable`  out  DATA_W/8: constant all-ones.
- `frame_ready`  out  1: level; at least one full bank is awaiting acknowledge.
- `frame_bank`  out  1: oldest full bank (valid while `frame_ready`).
- `frame_ack`  in  1: single-cycle pulse; frees `frame_bank`.
- `overflow`  out  1: sticky source-stall flag.
- `overflow_clr`  in  1: clears `overflow`.
- `frame_count`  out  16: completed frames, wraps 65535→0.

## Operation
- State per bank: `full[1:0]`. Registers: `wr_bank`, `rd_bank`, `idx` (ADDR_W-1 bits).
- FSM states:
  - IDLE: `enable=0`.
  - FILL: accepting samples.
  - WAIT_FREE: target bank `wr_bank` is full.
- FSM transitions:
  - IDLE→FILL when `enable=1` and `!full[wr_bank]`; IDLE→WAIT_FREE when `enable=1` and `full[wr_bank]`.
  - Any state→IDLE when `enable=0`. `idx` and `wr_bank` are retained, so re-enabling resumes mid-frame.
  - WAIT_FREE→FILL when `full[wr_bank]` clears.
- `snk_ready = (state==FILL)`, combinational from the state register.
- Accepting a beat in cycle N produces a registered write in cycle N+1:
  - `ram_chipselect=ram_write=1`;
  - `ram_address={wr_bank, idx}`;
  - `ram_writedata=snk_data`.
  - `idx` increments at the same edge.
- No accept → `ram_chipselect=ram_write=0`. Address and data hold their last values.
- Beat with `idx==FRAME_LEN-1`:
  - `idx←0`, `full[wr_bank]←1`, `wr_bank←~wr_bank`, `frame_count++`.
  - Next state is FILL if the new `wr_bank` is free after this edge's ack processing, otherwise WAIT_FREE.
- `frame_ready = |full`; `frame_bank = rd_bank`. Frames are reported strictly in completion order.
- `frame_ack` while `frame_ready=1`: `full[rd_bank]←0`, `rd_bank←~rd_bank`. `frame_ack` while `frame_ready=0` is ignored.
- Simultaneous frame completion and `frame_ack`:
  - Both updates apply at the same edge.
  - If the ack frees the bank being switched to, the FSM goes directly to FILL with no WAIT_FREE cycle.
- `overflow` is set on any cycle in WAIT_FREE with `snk_valid=1`.
  - `overflow_clr` clears it.
  - If set and clear occur in the same cycle, set wins.
- No data is dropped: the source is back-pressured and `overflow` only reports the stall.

## Timing
- Values during reset (and after release): all outputs 0 except `ram_byteenable` (all-ones); FSM in IDLE; `full=0`, `wr_bank=rd_bank=0`, `idx=0`.
- Reset asserted mid-frame aborts the frame immediately. The partial frame is discarded and is not reported.
- Accept-to-RAM-write latency: 1 cycle.
- Sustained throughput: 1 sample/cycle, including across bank boundaries when the next bank is free.
- `frame_ready` rises in cycle N+1 after the last beat is accepted in cycle N, the same cycle as that beat's RAM write.
- `frame_ack` in cycle M: `frame_ready` and `frame_bank` update in M+1. When leaving WAIT_FREE, `snk_ready=1` in M+1.
- `enable` low in cycle K: `snk_ready=0` from K+1. A write already registered still completes in K+1.

## Test plan
- Fill one frame: reset, `enable=1`, 160 back-to-back beats with data 0..159 → `ram_write` for 160 consecutive cycles, addresses 0..159, data equal to the address. Then `frame_ready=1`, `frame_bank=0`, `frame_count=1`.
- Ping-pong: a second frame (data 1000..1159) without ack → addresses 4096..4255. `frame_bank` stays 0. Ack → `frame_bank=1` next cycle. Ack again → `frame_ready=0`.
- Overflow / back-pressure:
  - After two unacked frames, `snk_ready=0` and held `snk_valid` → `overflow=1` and no `ram_write`.
  - Ack → next cycle `snk_ready=1`, and the next write goes to address 0.
  - `overflow_clr` → `overflow=0`.
- Simultaneous events: bank 1 full and pending; last beat of bank 0 accepted in the same cycle as `frame_ack` → next cycle `snk_ready=1`, `frame_bank=0`, and the next sample is written to 4096.
- Mid-frame reset: pulse `reset_n` low after 50 beats → all outputs 0 and `frame_count=0`. The next frame starts at address 0, and `frame_ready` is not asserted for the partial frame.
- Enable and gaps: random `snk_valid` gaps, with `enable` dropped after beat 80 and restored 10 cycles later → no writes while disabled. Addresses continue 80..159 and exactly one frame is reported.
